// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM: sequences PC, memory, IR, register file and ALU control.
// Optional macro BNE_EN adds bne decode; MEM_LAT sets how long memory reads are held.
module mips_mc_control #(
    parameter int MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] alu_ctl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t     cur_state;
    state_t     next_state;
    logic [3:0] lat_cnt;
    logic [3:0] lat_cnt_next;
    logic       lat_done;
    logic       is_store;
    logic       r_legal;
    logic [3:0] r_alu;
    logic       branch_take;
    logic       bne_decode;

    assign lat_done = (lat_cnt == 4'(MEM_LAT - 1));
    assign state    = cur_state;

    // is_store remembers lw vs sw so MEMADR does not depend on the opcode bus
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            lat_cnt   <= '0;
            is_store  <= 1'b0;
        end else begin
            cur_state <= next_state;
            lat_cnt   <= lat_cnt_next;
            if (cur_state == DECODE)
                is_store <= (opcode == OP_SW);
        end
    end

`ifdef BNE_EN
    logic is_bne;

    always_ff @(posedge clk) begin
        if (reset)
            is_bne <= 1'b0;
        else if (cur_state == DECODE)
            is_bne <= (opcode == OP_BNE);
    end

    assign bne_decode  = (opcode == OP_BNE);
    assign branch_take = zero ^ is_bne;
`else
    assign bne_decode  = 1'b0;
    assign branch_take = zero;
`endif

    always_comb begin
        r_legal = 1'b1;
        r_alu   = ALU_ADD;
        case (funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b100111: r_alu = ALU_NOR;
            6'b101010: r_alu = ALU_SLT;
            default:   r_legal = 1'b0;
        endcase
    end

    always_comb begin
        lat_cnt_next = '0;
        if ((cur_state == FETCH || cur_state == MEMRD) && !lat_done)
            lat_cnt_next = lat_cnt + 4'd1;
    end

    always_comb begin
        next_state = cur_state;
        alu_ctl    = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;

        case (cur_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (lat_done) begin
                    ir_write   = 1'b1;
                    pc_en      = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
                        if (r_legal) begin
                            next_state = EXEC;
                        end else begin
                            illegal    = 1'b1;
                            next_state = FETCH;
                        end
                    end
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDIEX;
                    default: begin
                        if (bne_decode) begin
                            next_state = BRANCH;
                        end else begin
                            illegal    = 1'b1;
                            next_state = FETCH;
                        end
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = is_store ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (lat_done)
                    next_state = MEMWB;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                next_state = FETCH;
            end
            MEMWR: begin
                mem_write  = 1'b1;
                iord       = 1'b1;
                next_state = FETCH;
            end
            EXEC: begin
                alu_src_a  = 1'b1;
                alu_ctl    = r_alu;
                next_state = ALUWB;
            end
            ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctl    = ALU_SUB;
                pc_src     = 2'b01;
                pc_en      = branch_take;
                next_state = FETCH;
            end
            JUMP: begin
                pc_src     = 2'b10;
                pc_en      = 1'b1;
                next_state = FETCH;
            end
            ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = ADDIWB;
            end
            ADDIWB: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            default: next_state = FETCH;
        endcase

        // Reset wins over every decoded output so nothing half-finished reaches the datapath
        if (reset) begin
            alu_ctl    = 4'b0000;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            pc_en      = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Scoreboard bench for mips_mc_control: a per-instruction summary model is queued at each
// IR load and compared against what a monitor accumulates over the instruction's cycles.
module tb_mips_mc_control;

    localparam int MEM_LAT    = 3;
    localparam int NUM_DIR    = 11;
    localparam int NUM_RANDOM = 150;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic [3:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
    logic [3:0] state;

    mips_mc_control #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_ctl(alu_ctl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int op; int fn;
        int cycles; int fetch_rd; int mem_rd; int mem_wr; int reg_wr; int reg_dst;
        int m2r; int pc_en; int pc_src; int illegal; int ir_wr; int alu; int bad;
    } rec_t;

    rec_t exp_q[$];
    rec_t acc;
    int   check_count = 0;
    int   pass_count  = 0;
    logic sb_active   = 1'b0;
    logic have_rec    = 1'b0;
    logic prev_fetch  = 1'b0;
    logic fetch_now;

    logic [5:0] legal_fn [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [5:0] dir_op   [NUM_DIR] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h04, 6'h02, 6'h08, 6'h00, 6'h3f, 6'h05, 6'h05};
    logic [5:0] dir_fn   [NUM_DIR] = '{6'h2a, 6'h11, 6'h05, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20, 6'h00, 6'h00};
    logic       dir_z    [NUM_DIR] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // ALU code an R-type funct should produce, -1 when the funct is unsupported
    function automatic int rAluOf(input logic [5:0] fn);
        case (fn)
            6'b100000: return 2;
            6'b100010: return 6;
            6'b100100: return 0;
            6'b100101: return 1;
            6'b100111: return 12;
            6'b101010: return 7;
            default:   return -1;
        endcase
    endfunction

    // Instruction-level expectations: cycle count, strobe counts and the writeback flavour
    function automatic rec_t model(input logic [5:0] op, input logic [5:0] fn, input logic z);
        rec_t e;
        int   taken;
        e = '{op: int'(op), fn: int'(fn), cycles: MEM_LAT + 1, fetch_rd: MEM_LAT, mem_rd: 0,
              mem_wr: 0, reg_wr: 0, reg_dst: -1, m2r: -1, pc_en: 1, pc_src: -1,
              illegal: 1, ir_wr: 1, alu: -1, bad: 0};
        taken = -1;
        if (op == 6'h00 && rAluOf(fn) >= 0) begin
            e.cycles = MEM_LAT + 3; e.illegal = 0; e.reg_wr = 1; e.reg_dst = 1; e.m2r = 0;
            e.alu = rAluOf(fn);
        end else if (op == 6'h23) begin
            e.cycles = 2 * MEM_LAT + 3; e.illegal = 0; e.mem_rd = MEM_LAT;
            e.reg_wr = 1; e.reg_dst = 0; e.m2r = 1;
        end else if (op == 6'h2b) begin
            e.cycles = MEM_LAT + 3; e.illegal = 0; e.mem_wr = 1;
        end else if (op == 6'h04) begin
            taken = int'(z);
        end else if (op == 6'h02) begin
            e.cycles = MEM_LAT + 2; e.illegal = 0; e.pc_en = 2; e.pc_src = 2;
        end else if (op == 6'h08) begin
            e.cycles = MEM_LAT + 3; e.illegal = 0; e.reg_wr = 1; e.reg_dst = 0; e.m2r = 0;
        end
`ifdef BNE_EN
        if (op == 6'h05)
            taken = int'(!z);
`endif
        if (taken >= 0) begin
            e.cycles = MEM_LAT + 2; e.illegal = 0; e.alu = 6;
            e.pc_en  = 1 + taken;
            e.pc_src = (taken == 1) ? 1 : -1;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic reportTimeout(input string name);
        check_count++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
        exp_q.push_back(model(op, fn, z));
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, "_strobes"}, int'({pc_en, mem_read, mem_write, ir_write, reg_write, illegal}), 0);
        checkOutput({name, "_selects"}, int'({alu_ctl, alu_src_a, alu_src_b, pc_src, iord, reg_dst, mem_to_reg}), 0);
    endtask

    task automatic waitIrWrite(output logic ok);
        ok = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (ir_write) begin
                ok = 1'b1;
                return;
            end
        end
        reportTimeout("ir_write_wait");
    endtask

    task automatic compareRecord(input rec_t a);
        rec_t  e;
        string t;
        if (exp_q.size() == 0) begin
            check_count++;
            $display("[TB] FAIL scoreboard_underflow: instruction completed with no expectation queued");
            return;
        end
        e = exp_q.pop_front();
        t = $sformatf("[op%02h fn%02h]", e.op, e.fn);
        checkOutput({"cycles", t}, a.cycles, e.cycles);
        checkOutput({"fetch_reads", t}, a.fetch_rd, e.fetch_rd);
        checkOutput({"mem_reads", t}, a.mem_rd, e.mem_rd);
        checkOutput({"mem_writes", t}, a.mem_wr, e.mem_wr);
        checkOutput({"reg_writes", t}, a.reg_wr, e.reg_wr);
        checkOutput({"reg_dst", t}, a.reg_dst, e.reg_dst);
        checkOutput({"mem_to_reg", t}, a.m2r, e.m2r);
        checkOutput({"pc_en_count", t}, a.pc_en, e.pc_en);
        checkOutput({"pc_src", t}, a.pc_src, e.pc_src);
        checkOutput({"illegal", t}, a.illegal, e.illegal);
        checkOutput({"ir_write", t}, a.ir_wr, e.ir_wr);
        checkOutput({"alu_ctl", t}, a.alu, e.alu);
        checkOutput({"invariants", t}, a.bad, e.bad);
    endtask

    // Monitor: an instruction starts on the first PC-addressed read cycle after a non-fetch cycle
    always @(negedge clk) begin
        if (sb_active) begin
            fetch_now = mem_read && !iord;
            if (fetch_now && !prev_fetch) begin
                if (have_rec)
                    compareRecord(acc);
                acc = '{op: 0, fn: 0, cycles: 0, fetch_rd: 0, mem_rd: 0, mem_wr: 0, reg_wr: 0,
                        reg_dst: -1, m2r: -1, pc_en: 0, pc_src: -1, illegal: 0, ir_wr: 0,
                        alu: -1, bad: 0};
                have_rec = 1'b1;
            end
            prev_fetch = fetch_now;
            if (have_rec) begin
                acc.cycles++;
                if (mem_read && !iord) acc.fetch_rd++;
                if (mem_read && iord)  acc.mem_rd++;
                if (mem_write)         acc.mem_wr++;
                if (reg_write) begin
                    acc.reg_wr++;
                    acc.reg_dst = int'(reg_dst);
                    acc.m2r     = int'(mem_to_reg);
                end
                if (pc_en) acc.pc_en++;
                if (pc_en && !mem_read) acc.pc_src = int'(pc_src);
                if (illegal)  acc.illegal++;
                if (ir_write) acc.ir_wr++;
                if (alu_src_a && alu_src_b == 2'b00) acc.alu = int'(alu_ctl);
                if ((mem_read && mem_write) || (reg_write && mem_write)) acc.bad++;
            end
        end
    end

    initial begin
        logic       ok;
        logic       found;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;

        repeat (2) @(negedge clk);
        checkResetOutputs("reset_init");
        @(posedge clk);
        #1 reset = 1'b0;

        // Start an add, then pull reset for three edges while it sits in EXEC
        waitIrWrite(ok);
        if (ok) begin
            opcode = 6'h00;
            funct  = 6'h20;
            found  = 1'b0;
            for (int c = 0; c < 16 && !found; c++) begin
                @(negedge clk);
                if (alu_src_a && alu_src_b == 2'b00) found = 1'b1;
            end
            if (!found) reportTimeout("exec_wait");
            checkOutput("exec_alu_add", int'(alu_ctl), 2);
        end
        reset = 1'b1;
        #1 checkResetOutputs("reset_mid_c1");
        @(negedge clk) checkResetOutputs("reset_mid_c2");
        @(negedge clk) checkResetOutputs("reset_mid_c3");
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        checkOutput("post_reset_mem_read", int'(mem_read), 1);
        checkOutput("post_reset_iord", int'(iord), 0);
        checkOutput("post_reset_alu_src_b", int'(alu_src_b), 1);
        checkOutput("post_reset_pc_en", int'(pc_en), (MEM_LAT == 1) ? 1 : 0);
        checkOutput("post_reset_reg_write", int'(reg_write), 0);
        sb_active = 1'b1;

        for (int i = 0; i < NUM_DIR + NUM_RANDOM; i++) begin
            if (i < NUM_DIR) begin
                op = dir_op[i];
                fn = dir_fn[i];
                z  = dir_z[i];
            end else begin
                fn = 6'($urandom);
                z  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 9))
                    0, 1:    begin op = 6'h00; fn = legal_fn[$urandom_range(0, 5)]; end
                    2:       op = 6'h23;
                    3:       op = 6'h2b;
                    4:       op = 6'h04;
                    5:       op = 6'h05;
                    6:       op = 6'h02;
                    7:       op = 6'h08;
                    8:       op = 6'h00;
                    default: op = 6'($urandom);
                endcase
            end
            waitIrWrite(ok);
            if (!ok) break;
            applyStimulus(op, fn, z);
        end

        for (int c = 0; c < 64 && exp_q.size() != 0; c++)
            @(negedge clk);
        if (exp_q.size() != 0) reportTimeout("scoreboard_drain");
        sb_active = 1'b0;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS main control FSM; the producer end of the ALU interface.
- Decodes opcode/funct and drives alu_ctl into the datapath ALU, and consumes its Zero flag for branch resolution.
- Also sequences memory, IR, register-file and PC enables for the shared-memory multicycle datapath.

Parameters:
MEM_LAT, 1, cycles mem_read is held in FETCH and MEMRD before advancing (legal range 1..15).

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU Zero flag (alu_out==0)
alu_ctl  output  4  ALU operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
alu_src_a  output  1  0=PC, 1=reg A
alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
pc_src  output  2  00=ALU result, 01=ALUOut reg, 10=jump target
pc_en  output  1  PC load enable (resolved, includes branch condition)
iord  output  1  0=PC address, 1=ALUOut address
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
ir_write  output  1  IR load enable
reg_dst  output  1  0=rt, 1=rd
mem_to_reg  output  1  0=ALUOut, 1=MDR
reg_write  output  1  register file write enable
illegal  output  1  one-cycle pulse on unsupported opcode/funct
state  output  4  current state encoding (debug)

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset:
  - While reset=1 at a clk edge, state<=FETCH and the latency counter is cleared.
  - While reset is high, every enable/strobe output (pc_en, mem_read, mem_write, ir_write, reg_write, illegal) is forced 0; mux selects and alu_ctl are 0.
  - Reset mid-instruction aborts it; no partial writeback occurs after the reset edge.
- Outputs are Moore-decoded from the state register. Exception: pc_en in BRANCH also depends on zero.
- States and transitions:
  - FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctl=0010, pc_src=00.
    - ir_write=1 and pc_en=1 only in the final counter cycle.
    - Holds MEM_LAT cycles, then goes to DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_ctl=0010 (branch target into ALUOut). Next state by opcode:
    - 000000 -> EXEC if funct is supported, else illegal=1 and -> FETCH.
    - 100011/101011 -> MEMADR.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - 001000 -> ADDIEX.
    - Any other opcode: illegal=1 and -> FETCH. The PC is already incremented, so the instruction is skipped.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_ctl=0010; lw -> MEMRD, sw -> MEMWR.
  - MEMRD: mem_read=1, iord=1; holds MEM_LAT cycles, then -> MEMWB.
  - MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1; -> FETCH.
  - MEMWR: mem_write=1, iord=1, exactly one cycle; -> FETCH.
  - EXEC: alu_src_a=1, alu_src_b=00; alu_ctl decoded from funct; -> ALUWB.
    - 100000->0010, 100010->0110, 100100->0000, 100101->0001, 100111->1100, 101010->0111.
  - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0; -> FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_ctl=0110, pc_src=01, pc_en=zero (combinational); -> FETCH.
  - JUMP: pc_src=10, pc_en=1; -> FETCH.
  - ADDIEX: alu_src_a=1, alu_src_b=10, alu_ctl=0010; -> ADDIWB.
  - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0; -> FETCH.
- Latency with MEM_LAT=1 (cycles per instruction):
  - R-type 4, lw 5, sw 4, beq 3, j 3, addi 4.
  - Each extra MEM_LAT cycle adds one cycle to FETCH, and one more to MEMRD for lw.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write and mem_write are never both 1.
  - opcode/funct are sampled only in DECODE/EXEC; the IR is stable there.
- In states that do not drive alu_ctl, it is 0010.

Optional Feature:
- BNE_EN: when defined, opcode 000101 (bne) is decoded in DECODE -> BRANCH.
  - A registered is_bne flag is latched in DECODE.
  - In BRANCH, pc_en = zero ^ is_bne.
- Without BNE_EN, opcode 000101 takes the illegal path (illegal=1, -> FETCH).

Test Plan:
- Reset held 3 cycles mid-EXEC -> all strobes 0 while reset is high; state=FETCH on the first cycle after release, with mem_read=1 and pc_en=1.
- R-type opcode=000000, funct=101010, MEM_LAT=1 -> alu_ctl=0111 in EXEC; reg_write=1 and reg_dst=1 exactly in cycle 4; back in FETCH at cycle 5.
- lw (100011), MEM_LAT=3 -> mem_read held 3 cycles in FETCH and 3 cycles in MEMRD with iord=1; reg_write=1 with mem_to_reg=1 once; 9 cycles total.
- beq (000100): zero=1 -> pc_en=1, pc_src=01 in BRANCH. Repeat with zero=0 -> pc_en=0; both return to FETCH after 3 cycles.
- Illegal funct 000000 under opcode 000000, and opcode 111111 -> illegal=1 for exactly one cycle in DECODE, no reg_write/mem_write, then FETCH.
- bne (000101), zero=0: with BNE_EN -> pc_en=1 in BRANCH; without BNE_EN -> illegal=1 in DECODE.
